// File: rtl/chan_mux_pkg.sv
// Shared constants and helpers for the channel multiplexer and its arbiter.
package chan_mux_pkg;

  localparam int MODE_SELECT      = 0;
  localparam int MODE_ROUND_ROBIN = 1;

  // Select/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above Ptr, wrapping from N-1 to 0.
module rr_arbiter
  import chan_mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  Req,
  input  logic [SW-1:0] Ptr,
  output logic [N-1:0]  Gnt,
  output logic [SW-1:0] GntIdx,
  output logic          Any
);

  localparam logic [SW:0] N_W = (SW+1)'(N);

  // Rotating priority scan; the first hit latches Any so later channels are masked.
  always_comb begin
    logic [SW:0]   raw;
    logic [SW-1:0] idx;
    logic          hit;
    Gnt    = '0;
    GntIdx = '0;
    Any    = 1'b0;
    raw    = '0;
    idx    = '0;
    hit    = 1'b0;
    for (int off = 0; off < N; off++) begin
      raw      = {1'b0, Ptr} + (SW+1)'(off);
      idx      = (raw >= N_W) ? SW'(raw - N_W) : SW'(raw);
      hit      = !Any && Req[idx];
      Gnt[idx] = Gnt[idx] | hit;
      GntIdx   = hit ? idx : GntIdx;
      Any      = Any | hit;
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered multiplexer with valid/ready on every channel; the channel is
// picked by an external select (MODE_SELECT) or an internal round-robin pointer.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int N    = 4,
  parameter  int MODE = MODE_SELECT,
  localparam int SW   = clog2_min1(N)
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic [N*W-1:0] InData,
  input  logic [N-1:0]  InValid,
  output logic [N-1:0]  InReady,
  input  logic [SW-1:0] Sel,
  output logic [W-1:0]  OutData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [SW-1:0] OutChan
);

  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  logic [N-1:0]  gnt_oh_s;
  logic [SW-1:0] gnt_idx_s;
  logic          gnt_any_s;
  logic          load_en_s;
  logic          xfer_s;
  logic [W-1:0]  sel_data_s;

  logic [W-1:0]  out_data_r;
  logic          out_valid_r;
  logic [SW-1:0] out_chan_r;
  logic [SW-1:0] ptr_r;

  generate
    if (MODE == MODE_ROUND_ROBIN) begin : g_rr
      logic sel_unused_s;
      assign sel_unused_s = ^Sel;

      rr_arbiter #(.N(N)) u_arb (
        .Req    (InValid),
        .Ptr    (ptr_r),
        .Gnt    (gnt_oh_s),
        .GntIdx (gnt_idx_s),
        .Any    (gnt_any_s)
      );
    end else begin : g_sel
      logic ptr_unused_s;
      assign ptr_unused_s = ^ptr_r;

      // Decode Sel; a value of N or above matches no channel and so grants nothing.
      always_comb begin
        gnt_oh_s = '0;
        for (int i = 0; i < N; i++) begin
          gnt_oh_s[i] = (Sel == SW'(i)) && InValid[i];
        end
      end

      assign gnt_idx_s = Sel;
      assign gnt_any_s = |gnt_oh_s;
    end
  endgenerate

  // The register can take a word when empty or when its current word leaves this cycle.
  assign load_en_s = !out_valid_r || OutReady;
  assign xfer_s    = gnt_any_s && load_en_s && Resetn;
  assign InReady   = gnt_oh_s & {N{load_en_s && Resetn}};

  // W-bit data select driven only by the grant index.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N; i++) begin
      sel_data_s = (gnt_idx_s == SW'(i)) ? InData[i*W +: W] : sel_data_s;
    end
  end

  // Output register: load on transfer, drop valid on a pop without refill, else hold.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      out_data_r  <= '0;
      out_chan_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (xfer_s) begin
      out_data_r  <= sel_data_s;
      out_chan_r  <= gnt_idx_s;
      out_valid_r <= 1'b1;
    end else if (OutReady) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Round-robin pointer moves just past the granted channel after each transfer.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + SW'(1'b1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign OutData  = out_data_r;
  assign OutValid = out_valid_r;
  assign OutChan  = out_chan_r;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Randomised scoreboard bench for chan_mux_rr in select and round-robin modes, plus an N=3 instance.
module tb_chan_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic [3:0]  s_in_ready, r_in_ready;
  logic [15:0] s_out_data, r_out_data;
  logic        s_out_valid, r_out_valid;
  logic [1:0]  s_out_chan, r_out_chan;

  logic [1:0]  t_sel;
  logic [2:0]  t_in_valid, t_in_ready;
  logic [47:0] t_in_data;
  logic        t_out_ready, t_out_valid;
  logic [15:0] t_out_data;
  logic [1:0]  t_out_chan;

  int          n_vec;
  int          n_err;
  logic [17:0] qs[$];
  logic [17:0] qr[$];
  logic        ms_full, mr_full;
  int          mptr;

  always #5 clk = ~clk;

  chan_mux_rr #(.W(16), .N(4), .MODE(0)) u_sel (
    .Clk(clk), .Resetn(rst_n), .InData(in_data), .InValid(in_valid), .InReady(s_in_ready),
    .Sel(sel), .OutData(s_out_data), .OutValid(s_out_valid), .OutReady(out_ready), .OutChan(s_out_chan)
  );

  chan_mux_rr #(.W(16), .N(4), .MODE(1)) u_rr (
    .Clk(clk), .Resetn(rst_n), .InData(in_data), .InValid(in_valid), .InReady(r_in_ready),
    .Sel(sel), .OutData(r_out_data), .OutValid(r_out_valid), .OutReady(out_ready), .OutChan(r_out_chan)
  );

  chan_mux_rr #(.W(16), .N(3), .MODE(0)) u_n3 (
    .Clk(clk), .Resetn(rst_n), .InData(t_in_data), .InValid(t_in_valid), .InReady(t_in_ready),
    .Sel(t_sel), .OutData(t_out_data), .OutValid(t_out_valid), .OutReady(t_out_ready), .OutChan(t_out_chan)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference models for both 4-channel instances.
  task automatic apply(input logic [1:0] s, input logic [3:0] v, input logic [63:0] d, input logic r);
    logic [3:0] exp_s;
    logic [3:0] exp_r;
    int         g;
    @(negedge clk);
    sel = s; in_valid = v; in_data = d; out_ready = r;
    #1;
    exp_s = 4'b0;
    if ((!ms_full || r) && v[s]) begin
      exp_s[s] = 1'b1;
      qs.push_back({s, d[s*16 +: 16]});
      ms_full = 1'b1;
    end else if (r) begin
      ms_full = 1'b0;
    end
    chk("sel_in_ready", 32'(s_in_ready), 32'(exp_s));

    exp_r = 4'b0;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && v[(mptr + k) % 4]) g = (mptr + k) % 4;
    end
    if ((!mr_full || r) && g >= 0) begin
      exp_r[g] = 1'b1;
      qr.push_back({2'(g), d[g*16 +: 16]});
      mr_full = 1'b1;
      mptr = (g + 1) % 4;
    end else if (r) begin
      mr_full = 1'b0;
    end
    chk("rr_in_ready", 32'(r_in_ready), 32'(exp_r));
  endtask

  task automatic reset_check();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_sel_valid", 32'(s_out_valid), 32'(0));
    chk("rst_sel_data",  32'(s_out_data),  32'(0));
    chk("rst_sel_chan",  32'(s_out_chan),  32'(0));
    chk("rst_sel_ready", 32'(s_in_ready),  32'(0));
    chk("rst_rr_valid",  32'(r_out_valid), 32'(0));
    chk("rst_rr_data",   32'(r_out_data),  32'(0));
    chk("rst_rr_ready",  32'(r_in_ready),  32'(0));
    qs.delete();
    qr.delete();
    ms_full = 1'b0;
    mr_full = 1'b0;
    mptr = 0;
    in_valid = 4'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: each word the DUT hands downstream must be the oldest one the model expects.
  initial begin : monitor
    logic [17:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (s_out_valid && out_ready) begin
          if (qs.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sel_out: got word %h, expected none", {s_out_chan, s_out_data});
          end else begin
            e = qs.pop_front();
            chk("sel_out", 32'({s_out_chan, s_out_data}), 32'(e));
          end
        end
        if (r_out_valid && out_ready) begin
          if (qr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rr_out: got word %h, expected none", {r_out_chan, r_out_data});
          end else begin
            e = qr.pop_front();
            chk("rr_out", 32'({r_out_chan, r_out_data}), 32'(e));
          end
        end
        chk("sel_backlog", 32'(qs.size() > 2), 32'(0));
        chk("rr_backlog",  32'(qr.size() > 2), 32'(0));
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0;
    ms_full = 1'b0; mr_full = 1'b0; mptr = 0;
    rst_n = 1'b0;
    sel = 2'd0; in_valid = 4'b0; in_data = 64'h0; out_ready = 1'b1;
    t_sel = 2'd0; t_in_valid = 3'b0; t_in_data = 48'h0; t_out_ready = 1'b1;
    #2;
    chk("por_sel_valid", 32'(s_out_valid), 32'(0));
    chk("por_sel_data",  32'(s_out_data),  32'(0));
    chk("por_rr_chan",   32'(r_out_chan),  32'(0));
    chk("por_n3_valid",  32'(t_out_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Select a single channel, then stall while inputs churn, then pop and refill together.
    apply(2'd2, 4'b0100, 64'h0000_BEEF_0000_0000, 1'b1);
    chk("t2_in_ready", 32'(s_in_ready), 32'(4'b0100));
    @(posedge clk); #1;
    chk("t2_out_data",  32'(s_out_data),  32'(16'hBEEF));
    chk("t2_out_chan",  32'(s_out_chan),  32'(2));
    chk("t2_out_valid", 32'(s_out_valid), 32'(1));
    for (int i = 0; i < 3; i++) begin
      apply(2'($urandom), 4'hF, {$urandom, $urandom}, 1'b0);
      chk("t3_stall_ready", 32'(s_in_ready), 32'(0));
      @(posedge clk); #1;
      chk("t3_stall_data", 32'(s_out_data), 32'(16'hBEEF));
      chk("t3_stall_chan", 32'(s_out_chan), 32'(2));
    end
    apply(2'd1, 4'b0010, 64'h0000_0000_1234_0000, 1'b1);
    @(posedge clk); #1;
    chk("t3_refill_data",  32'(s_out_data),  32'(16'h1234));
    chk("t3_refill_valid", 32'(s_out_valid), 32'(1));

    // Reset in the middle of a stall, then the pointer must restart at channel 0.
    apply(2'd0, 4'hF, 64'h1111_2222_3333_4444, 1'b1);
    apply(2'd0, 4'hF, 64'h5555_6666_7777_8888, 1'b0);
    reset_check();
    for (int i = 0; i < 8; i++) begin
      apply(2'($urandom), 4'hF, {$urandom, $urandom}, 1'b1);
      @(posedge clk); #1;
      chk("t4_rr_chan", 32'(r_out_chan), 32'(i % 4));
    end

    // Pointer at 3 with only the low two channels requesting wraps to 0, then 1.
    apply(2'd0, 4'b0100, 64'h0, 1'b1);
    apply(2'd0, 4'b0011, 64'h0, 1'b1);
    @(posedge clk); #1;
    chk("t5_wrap_first", 32'(r_out_chan), 32'(0));
    apply(2'd0, 4'b0011, 64'h0, 1'b1);
    @(posedge clk); #1;
    chk("t5_wrap_second", 32'(r_out_chan), 32'(1));
    apply(2'd0, 4'b0000, 64'h0, 1'b1);

    // Three-channel select: an out-of-range Sel grants nothing.
    @(negedge clk);
    t_sel = 2'd3; t_in_valid = 3'b111; t_in_data = 48'hAAAA_5A5A_C3C3;
    #1;
    chk("t6_sel3_ready", 32'(t_in_ready), 32'(0));
    @(posedge clk); #1;
    chk("t6_sel3_valid", 32'(t_out_valid), 32'(0));
    @(negedge clk);
    t_sel = 2'd1;
    #1;
    chk("t6_sel1_ready", 32'(t_in_ready), 32'(3'b010));
    @(posedge clk); #1;
    chk("t6_sel1_valid", 32'(t_out_valid), 32'(1));
    chk("t6_sel1_chan",  32'(t_out_chan),  32'(1));
    chk("t6_sel1_data",  32'(t_out_data),  32'(16'h5A5A));
    @(negedge clk);
    t_in_valid = 3'b000;

    // Random traffic with occasional backpressure and a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        apply(2'($urandom), 4'hF, {$urandom, $urandom}, 1'b0);
        reset_check();
      end
      apply(2'($urandom), 4'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end
    apply(2'd0, 4'b0000, 64'h0, 1'b1);
    apply(2'd0, 4'b0000, 64'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
